// File: rtl/mbt_stage_da_nlane.sv
// MBitTree lookup stage: per lane, gathers EBITS header bits from the current node and reads the
// child node from a lane-local table; leaf nodes pass through, leaf hits are counted (saturating).
module mbt_stage_da_nlane #(
   parameter int NUM_LANES    = 2,
   parameter int PACKET_WIDTH = 104,
   parameter int NODE_WIDTH   = 40,
   parameter int EBITS        = 3,
   parameter int BIT_WIDTH    = 8,
   parameter int NODE_ADDR    = 9,
   parameter int MEM_AW       = 4,
   parameter int USE_ROOT     = 0
) (
   input  logic                              clk,
   input  logic                              RSTn,
   input  logic [NUM_LANES*PACKET_WIDTH-1:0] packet_in,
   input  logic [NUM_LANES-1:0]              valid_in,
   input  logic [NUM_LANES*NODE_WIDTH-1:0]   node_in,
   input  logic                              upd_en,
   input  logic [MEM_AW-1:0]                 upd_addr,
   input  logic [NODE_WIDTH-1:0]             upd_data,
   input  logic                              root_wr_en,
   output logic [NUM_LANES*PACKET_WIDTH-1:0] packet_out,
   output logic [NUM_LANES-1:0]              valid_out,
   output logic [NUM_LANES*NODE_WIDTH-1:0]   node_out,
   output logic [NUM_LANES-1:0]              matched_out,
   output logic [31:0]                       leaf_cnt
);

   localparam int DEPTH   = 1 << MEM_AW;
   localparam int POS_LSB = 4 + EBITS;
   localparam int SUMW    = NODE_ADDR + EBITS + 1;
   localparam int CW      = $clog2(NUM_LANES + 1);

   logic [NODE_WIDTH-1:0] root_r;
   logic [CW-1:0]         hit_cnt_s;
   logic [32:0]           cnt_sum_s;

   // Root register, loaded from the update bus
   always_ff @(posedge clk) begin
      if (!RSTn) begin
         root_r <= '0;
      end else if (root_wr_en) begin
         root_r <= upd_data;
      end else begin
         root_r <= root_r;
      end
   end

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [NODE_WIDTH-1:0]   mem_r [DEPTH];
      logic [PACKET_WIDTH-1:0] pkt_s1_r, pkt_s2_r, pkt_o_r;
      logic [NODE_WIDTH-1:0]   node_s1_r, node_s2_r, node_o_r, rd_s2_r;
      logic                    val_s1_r, val_s2_r, val_o_r, leaf_s2_r, match_o_r;
      logic [PACKET_WIDTH-1:0] shift_s;
      logic [EBITS-1:0]        ebits_s;
      logic [SUMW-1:0]         sum_s;
      logic [MEM_AW-1:0]       addr_s;

      // Bit extraction; a shift past the header end yields 0 for out-of-range positions
      always_comb begin
         shift_s = '0;
         ebits_s = '0;
         for (int k = 0; k < EBITS; k++) begin
            shift_s    = pkt_s1_r >> node_s1_r[POS_LSB + k*BIT_WIDTH +: BIT_WIDTH];
            ebits_s[k] = shift_s[0] & node_s1_r[4 + k];
         end
         sum_s  = SUMW'(node_s1_r[NODE_WIDTH-1 -: NODE_ADDR]) + SUMW'(ebits_s);
         addr_s = sum_s[MEM_AW-1:0];
      end

      // Node table copy: broadcast write, read-first synchronous read
      always_ff @(posedge clk) begin
         if (upd_en) begin
            mem_r[upd_addr] <= upd_data;
         end
         rd_s2_r <= mem_r[addr_s];
      end

      // Three-stage lane pipeline
      always_ff @(posedge clk) begin
         if (!RSTn) begin
            pkt_s1_r  <= '0;
            val_s1_r  <= 1'b0;
            node_s1_r <= '0;
            pkt_s2_r  <= '0;
            val_s2_r  <= 1'b0;
            node_s2_r <= '0;
            leaf_s2_r <= 1'b0;
            pkt_o_r   <= '0;
            val_o_r   <= 1'b0;
            node_o_r  <= '0;
            match_o_r <= 1'b0;
         end else begin
            pkt_s1_r  <= packet_in[gi*PACKET_WIDTH +: PACKET_WIDTH];
            val_s1_r  <= valid_in[gi];
            node_s1_r <= (USE_ROOT != 0) ? root_r : node_in[gi*NODE_WIDTH +: NODE_WIDTH];
            pkt_s2_r  <= pkt_s1_r;
            val_s2_r  <= val_s1_r;
            node_s2_r <= node_s1_r;
            leaf_s2_r <= node_s1_r[0];
            pkt_o_r   <= pkt_s2_r;
            val_o_r   <= val_s2_r;
            node_o_r  <= leaf_s2_r ? node_s2_r : rd_s2_r;
            match_o_r <= leaf_s2_r ? node_s2_r[0] : rd_s2_r[0];
         end
      end

      assign packet_out[gi*PACKET_WIDTH +: PACKET_WIDTH] = pkt_o_r;
      assign node_out[gi*NODE_WIDTH +: NODE_WIDTH]       = node_o_r;
      assign valid_out[gi]                               = val_o_r;
      assign matched_out[gi]                             = match_o_r;
   end

   // Number of lanes presenting a qualified leaf hit this cycle
   always_comb begin
      hit_cnt_s = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         hit_cnt_s = hit_cnt_s + CW'(valid_out[i] & matched_out[i]);
      end
      cnt_sum_s = {1'b0, leaf_cnt} + 33'(hit_cnt_s);
   end

   // Saturating leaf counter
   always_ff @(posedge clk) begin
      if (!RSTn) begin
         leaf_cnt <= 32'h0000_0000;
      end else if (cnt_sum_s[32]) begin
         leaf_cnt <= 32'hFFFF_FFFF;
      end else begin
         leaf_cnt <= cnt_sum_s[31:0];
      end
   end

endmodule

// File: tb/tb_mbt_stage_da_nlane.sv
// Directed bench for mbt_stage_da_nlane: one node_in-driven instance and one root-driven instance.
module tb_mbt_stage_da_nlane;

   logic          clk = 1'b0;
   logic          RSTn;
   logic [207:0]  packet_in;
   logic [1:0]    valid_in;
   logic [79:0]   node_in;
   logic          upd_en;
   logic [3:0]    upd_addr;
   logic [39:0]   upd_data;
   logic          root_wr_en;
   logic [207:0]  pkt_o, r_pkt_o;
   logic [1:0]    val_o, r_val_o, match_o, r_match_o;
   logic [79:0]   node_o, r_node_o;
   logic [31:0]   cnt_o, r_cnt_o;
   logic [39:0]   exp_tbl [16];
   logic [39:0]   nd, old_w;
   logic [103:0]  p0, p1;
   int            total = 0;
   int            bad = 0;

   mbt_stage_da_nlane #(.USE_ROOT(0)) u_dut (
      .clk(clk), .RSTn(RSTn), .packet_in(packet_in), .valid_in(valid_in), .node_in(node_in),
      .upd_en(upd_en), .upd_addr(upd_addr), .upd_data(upd_data), .root_wr_en(root_wr_en),
      .packet_out(pkt_o), .valid_out(val_o), .node_out(node_o), .matched_out(match_o),
      .leaf_cnt(cnt_o));

   mbt_stage_da_nlane #(.USE_ROOT(1)) u_root (
      .clk(clk), .RSTn(RSTn), .packet_in(packet_in), .valid_in(valid_in), .node_in(node_in),
      .upd_en(upd_en), .upd_addr(upd_addr), .upd_data(upd_data), .root_wr_en(root_wr_en),
      .packet_out(r_pkt_o), .valid_out(r_val_o), .node_out(r_node_o), .matched_out(r_match_o),
      .leaf_cnt(r_cnt_o));

   always #5 clk = ~clk;

   function automatic logic [39:0] mk_node(input logic [8:0] base, input logic [7:0] q0,
                                           input logic [7:0] q1, input logic [7:0] q2,
                                           input logic [2:0] mask, input logic leaf);
      return {base, q2, q1, q0, mask, 3'b000, leaf};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_in  = 2'b00;
      packet_in = '0;
      node_in   = '0;
   endtask

   task automatic wr_tbl(input logic [3:0] a, input logic [39:0] d);
      upd_en = 1'b1; upd_addr = a; upd_data = d;
      tick();
      upd_en = 1'b0;
      exp_tbl[a] = d;
   endtask

   task automatic test_reset();
      RSTn = 1'b0; upd_en = 1'b0; root_wr_en = 1'b0; upd_addr = 4'h0; upd_data = 40'h0;
      idle();
      tick(); tick();
      if (val_o !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", val_o); end total++;
      if (node_o !== 80'h0) begin bad++; $display("FAIL reset_node got=%h exp=0", node_o); end total++;
      if (pkt_o !== 208'h0) begin bad++; $display("FAIL reset_pkt got=%h exp=0", pkt_o); end total++;
      if (match_o !== 2'b00) begin bad++; $display("FAIL reset_match got=%b exp=00", match_o); end total++;
      if (cnt_o !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", cnt_o); end total++;
      if (r_val_o !== 2'b00) begin bad++; $display("FAIL reset_root_valid got=%b exp=00", r_val_o); end total++;
      RSTn = 1'b1;
      for (int i = 0; i < 16; i++) wr_tbl(4'(i), {8'(8'hC0 + i), 24'h000000, 8'(i * 2)});
      wr_tbl(4'd5, 40'hA5_0000_0001);
   endtask

   task automatic test_root_lookup();
      upd_data = mk_node(9'd0, 8'd2, 8'd13, 8'd31, 3'b111, 1'b0);
      root_wr_en = 1'b1;
      tick();
      root_wr_en = 1'b0;
      p0 = (104'd1 << 2) | (104'd1 << 31);
      p1 = (104'd1 << 13);
      packet_in = {p1, p0}; valid_in = 2'b11;
      tick();
      idle();
      tick(); tick();
      if (r_node_o[39:0] !== 40'hA5_0000_0001) begin bad++; $display("FAIL root_l0_node got=%h exp=%h", r_node_o[39:0], 40'hA5_0000_0001); end total++;
      if (r_match_o !== 2'b01) begin bad++; $display("FAIL root_match got=%b exp=01", r_match_o); end total++;
      if (r_node_o[79:40] !== exp_tbl[2]) begin bad++; $display("FAIL root_l1_node got=%h exp=%h", r_node_o[79:40], exp_tbl[2]); end total++;
      if (r_val_o !== 2'b11) begin bad++; $display("FAIL root_valid got=%b exp=11", r_val_o); end total++;
      tick();
      if (r_val_o !== 2'b00) begin bad++; $display("FAIL root_valid_drop got=%b exp=00", r_val_o); end total++;
   endtask

   task automatic test_dual_lane();
      nd = mk_node(9'd0, 8'd0, 8'd1, 8'd2, 3'b111, 1'b0);
      p0 = 104'hDEAD_0000_0000_0000_0000_0000_F8;
      p1 = 104'h1234_5678_9ABC_DEF0_0000_0000_07;
      packet_in = {p1, p0}; node_in = {nd, nd}; valid_in = 2'b11;
      tick();
      idle();
      tick(); tick();
      if (node_o[39:0] !== exp_tbl[0]) begin bad++; $display("FAIL dual_l0_node got=%h exp=%h", node_o[39:0], exp_tbl[0]); end total++;
      if (node_o[79:40] !== exp_tbl[7]) begin bad++; $display("FAIL dual_l1_node got=%h exp=%h", node_o[79:40], exp_tbl[7]); end total++;
      if (pkt_o !== {p1, p0}) begin bad++; $display("FAIL dual_pkt got=%h exp=%h", pkt_o, {p1, p0}); end total++;
      if (val_o !== 2'b11) begin bad++; $display("FAIL dual_valid got=%b exp=11", val_o); end total++;
      if (match_o !== 2'b00) begin bad++; $display("FAIL dual_match got=%b exp=00", match_o); end total++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] e [3];
      e[0] = 4'd1; e[1] = 4'd3; e[2] = 4'd6;
      nd = mk_node(9'd8, 8'd0, 8'd1, 8'd2, 3'b111, 1'b0);
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin
            packet_in = {104'h0, 104'(e[c])}; node_in = {40'h0, nd}; valid_in = 2'b01;
         end else begin
            idle();
         end
         tick();
         if (c >= 2) begin
            if (node_o[39:0] !== exp_tbl[8 + e[c-2]]) begin bad++; $display("FAIL b2b_node%0d got=%h exp=%h", c - 2, node_o[39:0], exp_tbl[8 + e[c-2]]); end total++;
            if (val_o !== 2'b01) begin bad++; $display("FAIL b2b_valid%0d got=%b exp=01", c - 2, val_o); end total++;
         end
      end
   endtask

   task automatic test_leaf_pass();
      nd = mk_node(9'd3, 8'd0, 8'd0, 8'd0, 3'b000, 1'b0);
      packet_in = {104'h0, 104'hFFFF_FFFF}; node_in = {nd, 40'h0000000123}; valid_in = 2'b11;
      tick();
      idle();
      tick(); tick();
      if (node_o[39:0] !== 40'h0000000123) begin bad++; $display("FAIL leaf_node got=%h exp=0000000123", node_o[39:0]); end total++;
      if (node_o[79:40] !== exp_tbl[3]) begin bad++; $display("FAIL leaf_other_lane got=%h exp=%h", node_o[79:40], exp_tbl[3]); end total++;
      if (match_o !== 2'b01) begin bad++; $display("FAIL leaf_match got=%b exp=01", match_o); end total++;
   endtask

   task automatic test_wrap_range();
      nd = mk_node(9'h00F, 8'd0, 8'd1, 8'd200, 3'b111, 1'b0);
      packet_in = {{104{1'b1}}, 104'h3}; node_in = {nd, nd}; valid_in = 2'b11;
      tick();
      idle();
      tick(); tick();
      if (node_o[39:0] !== exp_tbl[2]) begin bad++; $display("FAIL wrap_l0 got=%h exp=%h", node_o[39:0], exp_tbl[2]); end total++;
      if (node_o[79:40] !== exp_tbl[2]) begin bad++; $display("FAIL range_l1 got=%h exp=%h", node_o[79:40], exp_tbl[2]); end total++;
   endtask

   task automatic test_collision();
      old_w = exp_tbl[4];
      nd = mk_node(9'd4, 8'd0, 8'd0, 8'd0, 3'b000, 1'b0);
      packet_in = '0; node_in = {40'h0, nd}; valid_in = 2'b01;
      tick();
      upd_en = 1'b1; upd_addr = 4'd4; upd_data = 40'h5A_1234_5678;
      tick();
      upd_en = 1'b0; exp_tbl[4] = 40'h5A_1234_5678;
      idle();
      tick();
      if (node_o[39:0] !== old_w) begin bad++; $display("FAIL collide_old got=%h exp=%h", node_o[39:0], old_w); end total++;
      tick();
      if (node_o[39:0] !== 40'h5A_1234_5678) begin bad++; $display("FAIL collide_new got=%h exp=5a12345678", node_o[39:0]); end total++;
   endtask

   task automatic test_counter_reset();
      idle();
      tick(); tick(); tick(); tick();
      force u_dut.leaf_cnt = 32'hFFFF_FFFE;
      #1;
      release u_dut.leaf_cnt;
      node_in = {40'h0000000123, 40'h0000000123}; valid_in = 2'b01;
      tick();
      valid_in = 2'b11;
      tick();
      idle();
      tick();
      if (cnt_o !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cnt_preload got=%h exp=fffffffe", cnt_o); end total++;
      tick();
      if (cnt_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cnt_one_hit got=%h exp=ffffffff", cnt_o); end total++;
      tick();
      if (cnt_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cnt_saturate got=%h exp=ffffffff", cnt_o); end total++;
      packet_in = {104'h55, 104'hAA}; node_in = {40'h0000000123, 40'h0000000123}; valid_in = 2'b11;
      tick(); tick(); tick(); tick();
      if (val_o !== 2'b11) begin bad++; $display("FAIL stream_valid got=%b exp=11", val_o); end total++;
      RSTn = 1'b0;
      tick();
      RSTn = 1'b1;
      if (val_o !== 2'b00) begin bad++; $display("FAIL midrst_valid got=%b exp=00", val_o); end total++;
      if (node_o !== 80'h0) begin bad++; $display("FAIL midrst_node got=%h exp=0", node_o); end total++;
      if (pkt_o !== 208'h0) begin bad++; $display("FAIL midrst_pkt got=%h exp=0", pkt_o); end total++;
      if (match_o !== 2'b00) begin bad++; $display("FAIL midrst_match got=%b exp=00", match_o); end total++;
      if (cnt_o !== 32'h0) begin bad++; $display("FAIL midrst_cnt got=%h exp=0", cnt_o); end total++;
      for (int c = 1; c < 3; c++) begin
         tick();
         if (val_o !== 2'b00) begin bad++; $display("FAIL post_rst_valid%0d got=%b exp=00", c, val_o); end total++;
      end
      tick();
      if (val_o !== 2'b11) begin bad++; $display("FAIL post_rst_resume got=%b exp=11", val_o); end total++;
      if (node_o !== {40'h0000000123, 40'h0000000123}) begin bad++; $display("FAIL post_rst_node got=%h", node_o); end total++;
      idle();
   endtask

   initial begin
      test_reset();
      test_root_lookup();
      test_dual_lane();
      test_back_to_back();
      test_leaf_pass();
      test_wrap_range();
      test_collision();
      test_counter_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
